// File: rtl/host_cmd_pkg.sv
// host_cmd_pkg: shared types and helpers for the host command serializer.
// Holds the command codes, CMD_TYPE encodings, FSM state enum, the command
// payload struct and the per-type frame count / frame byte helpers.
package host_cmd_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DIV_W  = 16;

    localparam logic [BYTE_W-1:0] CODE_WR      = 8'hAA;
    localparam logic [BYTE_W-1:0] CODE_RD      = 8'hBB;
    localparam logic [BYTE_W-1:0] CODE_ALU_OP  = 8'hCC;
    localparam logic [BYTE_W-1:0] CODE_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR      = 2'd0,
        CMD_RD      = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } state_t;

    typedef struct packed {
        cmd_type_t   typ;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  op_a;
        logic [7:0]  op_b;
        logic [3:0]  fun;
    } cmd_t;

    // Number of UART frames making up one command of the given type.
    function automatic logic [2:0] frame_count(input cmd_type_t t);
        logic [2:0] n;
        case (t)
            CMD_WR:     n = 3'd3;
            CMD_RD:     n = 3'd2;
            CMD_ALU_OP: n = 3'd4;
            default:    n = 3'd2;
        endcase
        return n;
    endfunction

    function automatic logic [BYTE_W-1:0] cmd_code(input cmd_type_t t);
        logic [BYTE_W-1:0] c;
        case (t)
            CMD_WR:     c = CODE_WR;
            CMD_RD:     c = CODE_RD;
            CMD_ALU_OP: c = CODE_ALU_OP;
            default:    c = CODE_ALU_NOP;
        endcase
        return c;
    endfunction

    // Byte carried by frame idx of command c.
    function automatic logic [BYTE_W-1:0] frame_byte(input cmd_t c, input logic [1:0] idx);
        logic [BYTE_W-1:0] b;
        b = {4'h0, c.fun};
        if (idx == 2'd0) begin
            b = cmd_code(c.typ);
        end else begin
            case (c.typ)
                CMD_WR:     b = (idx == 2'd1) ? {4'h0, c.addr} : c.wdata;
                CMD_RD:     b = {4'h0, c.addr};
                CMD_ALU_OP: b = (idx == 2'd1) ? c.op_a :
                                (idx == 2'd2) ? c.op_b : {4'h0, c.fun};
                default:    b = {4'h0, c.fun};
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_frame_ser.sv
// uart_frame_ser: shifts one byte out as start / 8 data (LSB first) /
// optional parity / stop, each bit held for i_div clocks.
// Ports: CLK, RST (sync, active high); i_load + i_data/i_par_en/i_par_typ/
// i_div load a frame when o_rdy_c is high; o_tx registered serial line;
// o_rdy_c high when idle or in the last cycle of the stop bit, so a new
// frame can follow the stop bit with no idle cycle.
module uart_frame_ser
    import host_cmd_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_par_en,
    input  logic              i_par_typ,
    input  logic [DIV_W-1:0]  i_div,
    output logic              o_tx,
    output logic              o_rdy_c
);

    state_t            r_state;
    logic [DIV_W-1:0]  r_baud_cnt;
    logic [DIV_W-1:0]  r_div;
    logic [2:0]        r_bit_idx;
    logic [BYTE_W-1:0] r_data;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_tx;
    logic              w_bit_end;
    logic              w_take;

    assign w_bit_end = (r_baud_cnt == r_div - 16'd1);
    assign o_rdy_c   = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end);
    assign w_take    = i_load && o_rdy_c;
    assign o_tx      = r_tx;

    // Bit sequencer; a load overrides the stop-bit exit so frames chain directly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_div      <= '0;
            r_bit_idx  <= '0;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_tx       <= 1'b1;
        end else if (w_take) begin
            r_state    <= ST_START;
            r_baud_cnt <= '0;
            r_div      <= i_div;
            r_bit_idx  <= '0;
            r_data     <= i_data;
            r_par_en   <= i_par_en;
            r_par_bit  <= (^i_data) ^ i_par_typ;
            r_tx       <= 1'b0;
        end else if (r_state != ST_IDLE) begin
            if (w_bit_end) begin
                r_baud_cnt <= '0;
                case (r_state)
                    ST_START: begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_data[0];
                    end
                    ST_DATA: begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= r_par_en ? ST_PARITY : ST_STOP;
                            r_tx    <= r_par_en ? r_par_bit : 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_data[r_bit_idx + 3'd1];
                        end
                    end
                    ST_PARITY: begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/host_cmd_tx.sv
// host_cmd_tx: encodes a register-file / ALU command into 2-4 UART frames
// and drives them onto TX_O with GAP_BITS idle bits between frames.
// Ports: CLK, RST (sync, active high); CMD_VLD/CMD_RDY accept handshake;
// CMD_TYPE, ADDR, WDATA, OP_A, OP_B, ALU_FUN command fields; BAUD_DIV,
// PAR_EN, PAR_TYP line settings (all latched at accept); TX_O serial line;
// BUSY command in progress; DONE one-cycle completion pulse.
module host_cmd_tx
    import host_cmd_pkg::*;
#(
    parameter int unsigned GAP_BITS = 1
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VLD,
    output logic              CMD_RDY,
    input  logic [1:0]        CMD_TYPE,
    input  logic [3:0]        ADDR,
    input  logic [7:0]        WDATA,
    input  logic [7:0]        OP_A,
    input  logic [7:0]        OP_B,
    input  logic [3:0]        ALU_FUN,
    input  logic [DIV_W-1:0]  BAUD_DIV,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    output logic              TX_O,
    output logic              BUSY,
    output logic              DONE
);

    localparam bit         HAS_GAP  = (GAP_BITS != 0);
    localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

    // ST_START covers a whole frame on the line; the serializer walks
    // START/DATA/PARITY/STOP within it.
    state_t            r_state;
    cmd_t              r_cmd;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_baud_cnt;
    logic              r_par_en;
    logic              r_par_typ;
    logic [1:0]        r_frame;
    logic [1:0]        r_last;
    logic [3:0]        r_gap_cnt;
    logic              r_rdy;
    logic              r_busy;
    logic              r_done;

    cmd_t              w_cmd_in;
    logic [DIV_W-1:0]  w_div_in;
    logic              w_accept;
    logic              w_ser_rdy;
    logic              w_frame_end;
    logic              w_more;
    logic              w_gap_bit_end;
    logic              w_gap_end;
    logic              w_load;
    logic [1:0]        w_next_frame;
    logic [BYTE_W-1:0] w_ld_data;
    logic              w_ld_par_en;
    logic              w_ld_par_typ;
    logic [DIV_W-1:0]  w_ld_div;
    logic              w_tx;

    assign w_cmd_in = '{typ: cmd_type_t'(CMD_TYPE), addr: ADDR, wdata: WDATA,
                        op_a: OP_A, op_b: OP_B, fun: ALU_FUN};
    assign w_div_in = (BAUD_DIV == 16'd0) ? 16'd1 : BAUD_DIV;

    assign w_accept      = CMD_VLD && r_rdy;
    assign w_next_frame  = r_frame + 2'd1;
    assign w_frame_end   = (r_state == ST_START) && w_ser_rdy;
    assign w_more        = (r_frame != r_last);
    assign w_gap_bit_end = (r_baud_cnt == r_div - 16'd1);
    assign w_gap_end     = (r_state == ST_GAP) && w_gap_bit_end && (r_gap_cnt == GAP_LAST);

    // Frame 0 is loaded straight from the live inputs on the accept edge.
    assign w_load       = w_accept || (w_frame_end && w_more && !HAS_GAP) || w_gap_end;
    assign w_ld_data    = w_accept ? frame_byte(w_cmd_in, 2'd0) : frame_byte(r_cmd, w_next_frame);
    assign w_ld_par_en  = w_accept ? PAR_EN  : r_par_en;
    assign w_ld_par_typ = w_accept ? PAR_TYP : r_par_typ;
    assign w_ld_div     = w_accept ? w_div_in : r_div;

    uart_frame_ser u_ser (
        .CLK       (CLK),
        .RST       (RST),
        .i_load    (w_load),
        .i_data    (w_ld_data),
        .i_par_en  (w_ld_par_en),
        .i_par_typ (w_ld_par_typ),
        .i_div     (w_ld_div),
        .o_tx      (w_tx),
        .o_rdy_c   (w_ser_rdy)
    );

    assign TX_O    = w_tx;
    assign CMD_RDY = r_rdy;
    assign BUSY    = r_busy;
    assign DONE    = r_done;

    // Command sequencer: frame index, inter-frame gap, handshake and DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_div      <= '0;
            r_baud_cnt <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_frame    <= '0;
            r_last     <= '0;
            r_gap_cnt  <= '0;
            r_rdy      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_START;
                        r_cmd     <= w_cmd_in;
                        r_div     <= w_div_in;
                        r_par_en  <= PAR_EN;
                        r_par_typ <= PAR_TYP;
                        r_frame   <= '0;
                        r_last    <= 2'(frame_count(cmd_type_t'(CMD_TYPE)) - 3'd1);
                        r_rdy     <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_frame_end) begin
                        if (!w_more) begin
                            r_state <= ST_IDLE;
                            r_rdy   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (HAS_GAP) begin
                            r_state    <= ST_GAP;
                            r_gap_cnt  <= '0;
                            r_baud_cnt <= '0;
                        end else begin
                            r_frame <= w_next_frame;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_gap_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_gap_cnt == GAP_LAST) begin
                            r_state <= ST_START;
                            r_frame <= w_next_frame;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 4'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_host_cmd_tx.sv
// tb_host_cmd_tx: directed, table-driven bench for host_cmd_tx. Two
// instances share inputs: u_dut_g1 (GAP_BITS=1) and u_dut_g0 (GAP_BITS=0).
module tb_host_cmd_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld;
    logic [1:0]  cmd_type;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [3:0]  alu_fun;
    logic [15:0] baud_div;
    logic        par_en;
    logic        par_typ;
    logic        rdy1, tx1, busy1, done1;
    logic        rdy0, tx0, busy0, done0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    host_cmd_tx #(.GAP_BITS(1)) u_dut_g1 (
        .CLK(clk), .RST(rst), .CMD_VLD(cmd_vld), .CMD_RDY(rdy1),
        .CMD_TYPE(cmd_type), .ADDR(addr), .WDATA(wdata), .OP_A(op_a), .OP_B(op_b),
        .ALU_FUN(alu_fun), .BAUD_DIV(baud_div), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .TX_O(tx1), .BUSY(busy1), .DONE(done1)
    );

    host_cmd_tx #(.GAP_BITS(0)) u_dut_g0 (
        .CLK(clk), .RST(rst), .CMD_VLD(cmd_vld), .CMD_RDY(rdy0),
        .CMD_TYPE(cmd_type), .ADDR(addr), .WDATA(wdata), .OP_A(op_a), .OP_B(op_b),
        .ALU_FUN(alu_fun), .BAUD_DIV(baud_div), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .TX_O(tx0), .BUSY(busy0), .DONE(done0)
    );

    // Command record with hand-computed frame bytes, parity bits (frame 0 in
    // the MSB) and the cycle in which DONE must appear.
    typedef struct {
        logic [1:0]  typ;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  op_a;
        logic [7:0]  op_b;
        logic [3:0]  fun;
        logic [15:0] div;
        logic        pe;
        logic        pt;
        bit          gap0;
        bit          disturb;
        int          nfr;
        logic [31:0] bytes;
        logic [3:0]  par;
        int          done_c;
    } vec_t;

    vec_t vecs [6];
    logic line_s [1024];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(rdy0 === 1'b1 && rdy1 === 1'b1) && n < 3000) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, rdy0 & rdy1}, 32'd1);
        tick();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   bd, gap, fb, base, bad_ctl, bad_line, bitpos;
        logic exp_b [256];
        logic s_tx, s_rdy, s_busy, s_done;
        logic [7:0] b, got;
        bd  = (v.div == 16'd0) ? 1 : int'(v.div);
        gap = v.gap0 ? 0 : 1;
        fb  = 10 + int'(v.pe);
        foreach (exp_b[k]) exp_b[k] = 1'b1;
        for (int f = 0; f < v.nfr; f++) begin
            base = f * (fb + gap);
            b = v.bytes[31 - 8*f -: 8];
            exp_b[base] = 1'b0;
            for (int k = 0; k < 8; k++) exp_b[base + 1 + k] = b[k];
            if (v.pe) exp_b[base + 9] = v.par[3 - f];
        end

        cmd_type = v.typ; addr = v.addr; wdata = v.wdata; op_a = v.op_a;
        op_b = v.op_b; alu_fun = v.fun; baud_div = v.div; par_en = v.pe; par_typ = v.pt;
        cmd_vld = 1'b1;
        chk($sformatf("v%0d_rdy_before", idx), {31'd0, v.gap0 ? rdy0 : rdy1}, 32'd1);
        tick();
        cmd_vld = 1'b0;

        bad_ctl = 0;
        for (int c = 1; c <= v.done_c; c++) begin
            s_tx   = v.gap0 ? tx0   : tx1;
            s_rdy  = v.gap0 ? rdy0  : rdy1;
            s_busy = v.gap0 ? busy0 : busy1;
            s_done = v.gap0 ? done0 : done1;
            line_s[c] = s_tx;
            if (c < v.done_c) begin
                if (s_done !== 1'b0 || s_rdy !== 1'b0 || s_busy !== 1'b1) bad_ctl++;
            end else begin
                chk($sformatf("v%0d_done", idx), {29'd0, s_done, s_rdy, s_busy}, 32'd6);
                chk($sformatf("v%0d_tx_after", idx), {31'd0, s_tx}, 32'd1);
            end
            if (v.disturb && c == 20) begin
                cmd_type = ~v.typ; addr = ~v.addr; wdata = 8'h5A; op_a = 8'hA5;
                op_b = 8'h77; alu_fun = ~v.fun; baud_div = 16'd7; par_en = ~v.pe;
                par_typ = ~v.pt; cmd_vld = 1'b1;
            end
            if (v.disturb && c == 21) cmd_vld = 1'b0;
            if (c < v.done_c) tick();
        end
        chk($sformatf("v%0d_ctl_while_busy", idx), 32'(bad_ctl), 32'd0);

        bad_line = 0;
        for (int c = 1; c < v.done_c; c++)
            if (line_s[c] !== exp_b[(c - 1) / bd]) bad_line++;
        chk($sformatf("v%0d_line_cycles_bad", idx), 32'(bad_line), 32'd0);

        // Mid-bit decode of every frame.
        for (int f = 0; f < v.nfr; f++) begin
            base = f * (fb + gap);
            for (int k = 0; k < 8; k++) begin
                bitpos = base + 1 + k;
                got[k] = line_s[bitpos * bd + bd / 2 + 1];
            end
            chk($sformatf("v%0d_f%0d_byte", idx, f), {24'd0, got}, {24'd0, v.bytes[31 - 8*f -: 8]});
            chk($sformatf("v%0d_f%0d_start_stop", idx, f),
                {30'd0, line_s[(base + fb - 1) * bd + bd / 2 + 1], line_s[base * bd + bd / 2 + 1]}, 32'd2);
            if (v.pe)
                chk($sformatf("v%0d_f%0d_parity", idx, f),
                    {31'd0, line_s[(base + 9) * bd + bd / 2 + 1]}, {31'd0, v.par[3 - f]});
        end
    endtask

    initial begin
        int n_done;
        vecs[0] = '{2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3, 32'hAA053C00, 4'b0000, 129};
        vecs[1] = '{2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4, 32'hCC123402, 4'b0011, 95};
        vecs[2] = '{2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2, 32'hBB090000, 4'b1100, 23};
        vecs[3] = '{2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hA, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2, 32'hDD0A0000, 4'b0000, 64};
        vecs[4] = '{2'd0, 4'hF, 8'h81, 8'h00, 8'h00, 4'h0, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 32'hAA0F8100, 4'b1110, 36};
        vecs[5] = '{2'd2, 4'h0, 8'h00, 8'hFF, 8'h00, 4'hF, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4, 32'hCCFF000F, 4'b0000, 89};

        rst = 1'b1; cmd_vld = 1'b0; cmd_type = 2'd0; addr = 4'h0; wdata = 8'h00;
        op_a = 8'h00; op_b = 8'h00; alu_fun = 4'h0; baud_div = 16'd1; par_en = 1'b0; par_typ = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_g1", {28'd0, tx1, rdy1, busy1, done1}, 32'hC);
        chk("reset_g0", {28'd0, tx0, rdy0, busy0, done0}, 32'hC);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
            if (i == 0)
                chk("aa_first_bits", {28'd0, line_s[7], line_s[11], line_s[15], line_s[19]}, 32'h5);
            wait_idle();
        end

        // Back-to-back type 3 commands with CMD_VLD held high, BAUD_DIV=1.
        cmd_type = 2'd3; alu_fun = 4'h5; baud_div = 16'd1; par_en = 1'b0; par_typ = 1'b0;
        cmd_vld = 1'b1;
        tick();
        for (int c = 1; c <= 44; c++) begin
            if (c == 21) chk("b2b_g0_done", {31'd0, done0}, 32'd1);
            if (c == 22) begin
                chk("b2b_g1_done_cycle", {29'd0, done1, rdy1, tx1}, 32'd7);
                chk("b2b_g0_second_start", {31'd0, tx0}, 32'd0);
            end
            if (c == 23) chk("b2b_g1_second_start", {29'd0, tx1, busy1, done1}, 32'd2);
            if (c == 44) chk("b2b_g1_second_done", {31'd0, done1}, 32'd1);
            if (c == 30) cmd_vld = 1'b0;
            if (c < 44) tick();
        end
        wait_idle();

        // Reset in the middle of a data bit.
        cmd_type = 2'd0; addr = 4'h5; wdata = 8'h3C; baud_div = 16'd4; par_en = 1'b0;
        cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0;
        repeat (13) tick();
        chk("rst_pre_data_bit", {30'd0, tx1, busy1}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_g1", {28'd0, tx1, rdy1, busy1, done1}, 32'hC);
        chk("rst_mid_g0", {28'd0, tx0, rdy0, busy0, done0}, 32'hC);
        n_done = 0;
        for (int c = 0; c < 200; c++) begin
            if (done1 === 1'b1 || done0 === 1'b1 || tx1 !== 1'b1) n_done++;
            tick();
        end
        chk("rst_no_done_idle_line", 32'(n_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
